// File: rtl/instr_pkg.sv
// instr_pkg: opcode constants, opcode field bounds and issue-state encoding shared by the issue unit and decoder
package instr_pkg;
    localparam int OP_HI = 31;
    localparam int OP_LO = 25;
    localparam logic [6:0] OP_INT  = 7'h28;
    localparam logic [6:0] OP_HALT = 7'h7F;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_ISSUE,
        S_INT_WAIT,
        S_HALT
    } issue_state_t;
endpackage

// File: rtl/instr_issue.sv
// instr_issue: fetches instruction words from synchronous memory and issues them to the decoder over valid/ready
//   clk, rst_n                 clock, async active-low reset
//   start, start_addr, stop    run control (stop wins over everything)
//   int_req                    releases the interrupt-wait state
//   imem_rd, imem_addr         memory read request; imem_data returns one cycle later
//   r_out, r_valid, r_ready    decoder handshake
//   busy, halted, waiting      state flags; instr_cnt counts accepted words since start
module instr_issue
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              int_req,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       r_out,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              busy,
    output logic              halted,
    output logic              waiting,
    output logic [CNT_W-1:0]  instr_cnt
);
    issue_state_t      r_state;
    issue_state_t      w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [6:0]        w_op;
    logic              w_accept;
    logic              w_go;
    logic              w_adv;

    assign w_op     = r_data[OP_HI:OP_LO];
    assign w_accept = r_valid && r_ready;
    assign w_go     = (r_state == S_IDLE || r_state == S_HALT) && start;
    // halt keeps pc on the halt word; interrupt-wait advances only when released
    assign w_adv    = (r_state == S_ISSUE && w_accept && w_op != OP_HALT && w_op != OP_INT)
                   || (r_state == S_INT_WAIT && int_req);

    assign imem_rd   = r_state == S_REQ;
    assign imem_addr = r_pc;
    assign r_out     = r_data;
    assign r_valid   = r_state == S_ISSUE;
    assign busy      = r_state != S_IDLE && r_state != S_HALT;
    assign halted    = r_state == S_HALT;
    assign waiting   = r_state == S_INT_WAIT;
    assign instr_cnt = r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: w_next = start ? S_REQ : r_state;
            S_REQ:          w_next = S_DATA;
            S_DATA:         w_next = S_ISSUE;
            S_ISSUE:        w_next = !w_accept ? S_ISSUE : w_op == OP_HALT ? S_HALT
                                   : w_op == OP_INT ? S_INT_WAIT : S_REQ;
            S_INT_WAIT:     w_next = int_req ? S_REQ : S_INT_WAIT;
            default:        w_next = S_IDLE;
        endcase
        if (stop) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // a stop discards any response in flight and freezes pc
            if (!stop) begin
                if (w_go) r_pc <= start_addr;
                else if (w_adv) r_pc <= r_pc + 1'b1;
                if (r_state == S_DATA) r_data <= imem_data;
            end
            // an accept coinciding with stop is still counted
            if (w_go && !stop) r_cnt <= '0;
            else if (w_accept) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue unit that feeds the instruction decoder. It fetches 32-bit instruction words from a synchronous instruction memory, starting at a given address. Each word is presented to the decoder's `r_in` through a valid/ready handshake. The unit stops fetching after an interrupt-wait instruction until an interrupt arrives, and stops completely on a halt instruction. It sits between the instruction memory and the first pipeline stage of the decoder.

## Interface

Clocking is fixed: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

**Parameters**
- `ADDR_W`, default 8: instruction memory address width.
- `CNT_W`, default 16: width of the issued-instruction counter.

**Ports**
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins fetching at `start_addr`. Accepted only in IDLE or HALT.
- `start_addr`  in  ADDR_W  first instruction address.
- `stop`  in  1  synchronous abort to IDLE from any state.
- `int_req`  in  1  interrupt pulse; releases INT_WAIT.
- `imem_rd`  out  1  memory read strobe.
- `imem_addr`  out  ADDR_W  memory read address.
- `imem_data`  in  32  read data, valid exactly one cycle after `imem_rd`.
- `r_out`  out  32  instruction word to the decoder's `r_in`.
- `r_valid`  out  1  `r_out` holds an instruction.
- `r_ready`  in  1  decoder accepts the word this cycle.
- `busy`  out  1  state is not IDLE and not HALT.
- `halted`  out  1  state is HALT.
- `waiting`  out  1  state is INT_WAIT.
- `instr_cnt`  out  CNT_W  number of instructions accepted since the last `start`.

## Operation

- Opcode field is `r_out[31:25]`.
- Package constants: `OP_INT = 7'h28` (interrupt wait) and `OP_HALT = 7'h7F`.
- States: IDLE, REQ, DATA, ISSUE, INT_WAIT, HALT.
- **IDLE / HALT:**
  - on `start` (and no `stop`): `pc <= start_addr`, `instr_cnt <= 0`, go to REQ.
- **REQ:**
  - `imem_rd = 1`, `imem_addr = pc`; go to DATA.
- **DATA:**
  - `r_out <= imem_data`; go to ISSUE.
- **ISSUE:**
  - `r_valid = 1`; `r_out` is held stable until accepted.
  - Accept means `r_valid && r_ready`. On accept, `instr_cnt` increments, wrapping at 2^CNT_W.
  - If the opcode is `OP_HALT`: go to HALT. `pc` does not advance.
  - If the opcode is `OP_INT`: go to INT_WAIT.
  - Otherwise: `pc <= pc + 1` (wraps modulo 2^ADDR_W), go to REQ.
- **INT_WAIT:**
  - on `int_req`: `pc <= pc + 1`, go to REQ.
- `int_req` outside INT_WAIT is ignored and not remembered.
- `start` outside IDLE/HALT is ignored.
- `stop` has priority over every other event, including `start`, `int_req` and an accept in the same cycle. Its effect:
  - next state is IDLE, `r_valid` drops;
  - an instruction accepted in that same cycle is still counted.
- `r_out` is registered. `r_valid`, `imem_rd`, `busy`, `halted` and `waiting` decode directly from the state register.

## Timing

**Reset values:**
- state IDLE; `pc = 0`, `r_out = 0`, `instr_cnt = 0`;
- `r_valid = 0`, `imem_rd = 0`, `imem_addr = 0`;
- `busy = 0`, `halted = 0`, `waiting = 0`.

**Latency:**
- `start` is sampled at edge T0, giving `imem_rd = 1` during cycle T1.
- Data is captured at T2, so `r_valid = 1` from cycle T3.
- Back-to-back issue, with `r_ready` held at 1, gives one instruction every 3 cycles.
- `int_req` sampled at edge E gives `imem_rd` in the cycle after E.

**Boundaries:**
- `pc = 2^ADDR_W - 1` followed by a normal accept wraps to 0.
- Reset asserted mid-fetch clears everything immediately.
- A read response in flight is discarded after `stop` or reset.

## Structure

- Package `instr_pkg`:
  - opcode constants `OP_INT`, `OP_HALT`;
  - opcode field bounds (31:25);
  - state enum `issue_state_t`.
- The decoder should later import the same package.
- Single module; no sub-module is needed.

## Test plan

1. **Straight-line run:** memory[0..2] = `32'h0155_A75C`, `32'h0325_456B`, `32'hFE00_0000` (halt); `start`, `start_addr = 0`, `r_ready = 1`.
   - Three words appear in order; first `r_valid` 3 cycles after `start`.
   - Ends with `halted = 1`, `instr_cnt = 3`.
2. **Backpressure:** hold `r_ready = 0` for 5 cycles on the first word.
   - `r_out` stays stable and `r_valid` stays 1.
   - No `imem_rd` until the accept; `instr_cnt` increments once.
3. **Interrupt wait:** memory[4] = `32'h5000_0000` (`OP_INT`); start at 4.
   - After the accept, `waiting = 1` and there is no read.
   - `int_req` pulsed earlier is ignored. A later `int_req` gives `imem_rd` at `imem_addr = 5` on the next cycle.
4. **Wrap:** `ADDR_W = 8`, start at 255 with a non-halt word.
   - The next `imem_addr` is 0.
5. **Priority:** `stop` and `start` in the same cycle while in ISSUE with `r_ready = 1`.
   - Next state is IDLE and `r_valid = 0`.
   - `instr_cnt` still increments.
   - `start` has no effect until the following cycle.
6. **Reset mid-operation:** assert `rst_n = 0` during DATA.
   - All outputs hold their reset values immediately, without waiting for a clock edge.
